// File: rtl/mem_access_ctrl.sv
// Execute-to-memory access stage: turns LW/SW/PUSH/POP/CALL/RET into one registered
// data-memory request with a valid/ready handshake, stack pointer tracking and sticky error flags.
module mem_access_ctrl #(
    parameter logic [31:0] SP_INIT     = 32'd1024,
    parameter logic [31:0] STACK_LIMIT = 32'd768,
    parameter logic [31:0] MEM_TOP     = 32'd1020
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  opcode,
    input  logic [31:0] alu_result,
    input  logic [31:0] rd_data,
    input  logic [31:0] pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] sp,
    output logic        is_ret,
    output logic        op_err,
    output logic        ovf,
    output logic        unf,
    output logic        addr_err,
    input  logic        err_clr
);

    localparam logic [5:0] OP_LW   = 6'b000101;
    localparam logic [5:0] OP_SW   = 6'b000111;
    localparam logic [5:0] OP_PUSH = 6'b001111;
    localparam logic [5:0] OP_POP  = 6'b010000;
    localparam logic [5:0] OP_CALL = 6'b001101;
    localparam logic [5:0] OP_RET  = 6'b001110;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        logic        ret;
        logic        err;
    } op_t;

    op_t         op_q, op_d;
    logic [31:0] sp_q, sp_d, sp_dec, sp_inc;
    logic        valid_q, accept, bad_addr;
    logic        ovf_q, unf_q, aerr_q;
    logic        ovf_set, unf_set, aerr_set;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign sp_dec   = sp_q - 32'd4;
    assign sp_inc   = sp_q + 32'd4;
    assign bad_addr = (alu_result[1:0] != 2'b00) || (alu_result > MEM_TOP);

    // Decode the presented operation into the request that would be registered on accept.
    always_comb begin
        op_d     = '{addr: alu_result, wdata: rd_data, rd: 1'b0, wr: 1'b0, ret: 1'b0, err: 1'b0};
        sp_d     = sp_q;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        aerr_set = 1'b0;
        case (opcode)
            OP_LW, OP_SW: begin
                if (bad_addr) begin
                    op_d.err = 1'b1;
                    aerr_set = 1'b1;
                end else begin
                    op_d.rd = (opcode == OP_LW);
                    op_d.wr = (opcode == OP_SW);
                end
            end
            OP_PUSH, OP_CALL: begin
                op_d.addr  = sp_dec;
                op_d.wdata = (opcode == OP_CALL) ? pc + 32'd1 : rd_data;
                if (sp_dec < STACK_LIMIT) begin
                    op_d.err = 1'b1;
                    ovf_set  = 1'b1;
                end else begin
                    op_d.wr = 1'b1;
                    sp_d    = sp_dec;
                end
            end
            OP_POP, OP_RET: begin
                op_d.addr = sp_q;
                op_d.ret  = (opcode == OP_RET);
                if (sp_q >= SP_INIT) begin
                    op_d.err = 1'b1;
                    unf_set  = 1'b1;
                end else begin
                    op_d.rd = 1'b1;
                    sp_d    = sp_inc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            sp_q    <= SP_INIT;
        end else if (accept) begin
            valid_q <= 1'b1;
            op_q    <= op_d;
            sp_q    <= sp_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Sticky flags: a new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            aerr_q <= 1'b0;
        end else begin
            ovf_q  <= (accept && ovf_set)  || (ovf_q  && !err_clr);
            unf_q  <= (accept && unf_set)  || (unf_q  && !err_clr);
            aerr_q <= (accept && aerr_set) || (aerr_q && !err_clr);
        end
    end

    // Strobes only on the transfer cycle, so a stalled request is issued exactly once.
    assign mem_read  = valid_q && out_ready && op_q.rd && !op_q.err;
    assign mem_write = valid_q && out_ready && op_q.wr && !op_q.err;
    assign out_valid = valid_q;
    assign mem_addr  = op_q.addr;
    assign mem_wdata = op_q.wdata;
    assign sp        = sp_q;
    assign is_ret    = valid_q && op_q.ret;
    assign op_err    = valid_q && op_q.err;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign addr_err  = aerr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: an op-level reference model checked every cycle, plus
// directed scenarios with literal expectations on the strobe log.
module tb_mem_access_ctrl;

    localparam logic [31:0] SP_INIT     = 32'd1024;
    localparam logic [31:0] STACK_LIMIT = 32'd768;
    localparam logic [31:0] MEM_TOP     = 32'd1020;

    localparam logic [5:0] LW = 6'b000101, SW = 6'b000111, PUSH = 6'b001111;
    localparam logic [5:0] POP = 6'b010000, CALL = 6'b001101, RET = 6'b001110;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, err_clr;
    logic [5:0]  opcode;
    logic [31:0] alu_result, rd_data, pc;
    logic        in_ready, out_valid, mem_read, mem_write, is_ret, op_err, ovf, unf, addr_err;
    logic [31:0] mem_addr, mem_wdata, sp;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    mem_access_ctrl #(.SP_INIT(SP_INIT), .STACK_LIMIT(STACK_LIMIT), .MEM_TOP(MEM_TOP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .alu_result(alu_result), .rd_data(rd_data), .pc(pc), .out_ready(out_ready),
        .out_valid(out_valid), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .sp(sp), .is_ret(is_ret), .op_err(op_err), .ovf(ovf), .unf(unf),
        .addr_err(addr_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: one transaction at a time ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd, wr, ret, err, ovf, unf, aerr;
        logic [31:0] nsp;
    } mres_t;

    function automatic mres_t model_op(input logic [5:0] o, input logic [31:0] a,
                                       input logic [31:0] d, input logic [31:0] p,
                                       input logic [31:0] s);
        mres_t r;
        longint unsigned below = longint'(s) - 4;
        r = '0;
        r.nsp = s;
        if (o == LW || o == SW) begin
            if ((a % 4) != 0 || longint'(a) > longint'(MEM_TOP)) begin
                r.err = 1'b1; r.aerr = 1'b1;
            end else begin
                r.addr = a; r.wdata = d; r.rd = (o == LW); r.wr = (o == SW);
            end
        end else if (o == PUSH || o == CALL) begin
            if (s < 4 || below < longint'(STACK_LIMIT)) begin
                r.err = 1'b1; r.ovf = 1'b1;
            end else begin
                r.addr = s - 4; r.wr = 1'b1; r.nsp = s - 4;
                r.wdata = (o == CALL) ? p + 1 : d;
            end
        end else if (o == POP || o == RET) begin
            r.ret = (o == RET);
            if (s >= SP_INIT) begin
                r.err = 1'b1; r.unf = 1'b1;
            end else begin
                r.addr = s; r.rd = 1'b1; r.nsp = s + 4;
            end
        end
        return r;
    endfunction

    mres_t       nxt, m_op;
    logic        m_valid, m_ovf, m_unf, m_aerr, m_acc;
    logic [31:0] m_sp;

    always_comb nxt = model_op(opcode, alu_result, rd_data, pc, m_sp);
    assign m_acc = in_valid && (!m_valid || out_ready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_op <= '0; m_sp <= SP_INIT;
            m_ovf <= 1'b0; m_unf <= 1'b0; m_aerr <= 1'b0;
        end else begin
            if (m_acc) begin
                m_valid <= 1'b1; m_op <= nxt; m_sp <= nxt.nsp;
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
            m_ovf  <= (m_acc && nxt.ovf)  || (m_ovf  && !err_clr);
            m_unf  <= (m_acc && nxt.unf)  || (m_unf  && !err_clr);
            m_aerr <= (m_acc && nxt.aerr) || (m_aerr && !err_clr);
        end
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ret;
        int          cyc;
    } strobe_t;
    strobe_t log_q[$];

    // Per-cycle compare, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_strobes", {mem_read, mem_write}, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_flags", {is_ret, op_err, ovf, unf, addr_err}, 0);
            chk("rst_sp", sp, SP_INIT);
        end else begin
            chk("in_ready", in_ready, !m_valid || out_ready);
            chk("out_valid", out_valid, m_valid);
            chk("mem_read", mem_read, m_valid && out_ready && m_op.rd);
            chk("mem_write", mem_write, m_valid && out_ready && m_op.wr);
            chk("sp", sp, m_sp);
            chk("sticky", {ovf, unf, addr_err}, {m_ovf, m_unf, m_aerr});
            if (m_valid) chk("op_flags", {is_ret, op_err}, {m_op.ret, m_op.err});
            if (m_valid && out_ready && (m_op.rd || m_op.wr)) chk("mem_addr", mem_addr, m_op.addr);
            if (m_valid && out_ready && m_op.wr) chk("mem_wdata", mem_wdata, m_op.wdata);
            if (mem_read || mem_write)
                log_q.push_back('{wr: mem_write, addr: mem_addr, data: mem_wdata, ret: is_ret, cyc: cyc});
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] p);
        int n = 0;
        in_valid = 1'b1; opcode = o; alu_result = a; rd_data = d; pc = p;
        while (!(!m_valid || out_ready) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) begin
            checks++; failures++;
            $display("FAIL issue_timeout: got no accept expected accept within 20 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        log_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; opcode = '0; alu_result = '0; rd_data = '0; pc = '0;
        out_ready = 1'b1; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_reset_sp", sp, 32'd1024);
        chk("lit_reset_valid", out_valid, 0);
        rst_n = 1'b1;
        #1 chk("lit_reset_in_ready", in_ready, 1);

        // CALL then RET
        log_q.delete();
        issue(CALL, 32'h0, 32'h0, 32'h40);
        chk("lit_call_sp", sp, 32'd1020);
        issue(RET, 32'h0, 32'h0, 32'h0);
        idle(2);
        chk("lit_callret_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("lit_call_strobe", {log_q[0].wr, log_q[0].addr, log_q[0].data}, {1'b1, 32'd1020, 32'h41});
            chk("lit_ret_strobe", {log_q[1].wr, log_q[1].addr, log_q[1].ret}, {1'b0, 32'd1020, 1'b1});
        end
        chk("lit_ret_sp", sp, 32'd1024);

        // stalled PUSH: exactly one strobe once out_ready rises
        log_q.delete();
        out_ready = 1'b0;
        issue(PUSH, 32'h0, 32'hDEADBEEF, 32'h0);
        repeat (3) begin
            chk("lit_stall_in_ready", in_ready, 0);
            chk("lit_stall_sp", sp, 32'd1020);
            @(posedge clk); #1;
        end
        chk("lit_stall_no_strobe", log_q.size(), 0);
        out_ready = 1'b1;
        idle(3);
        chk("lit_stall_one_strobe", log_q.size(), 1);
        if (log_q.size() == 1)
            chk("lit_stall_write", {log_q[0].addr, log_q[0].data}, {32'd1020, 32'hDEADBEEF});

        // POP on empty stack, clear, then set-wins-over-clear
        do_reset();
        issue(POP, 32'h0, 32'h0, 32'h0);
        chk("lit_unf_flags", {op_err, unf}, 2'b11);
        chk("lit_unf_sp", sp, 32'd1024);
        idle(1);
        chk("lit_unf_no_strobe", log_q.size(), 0);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("lit_unf_cleared", unf, 0);
        err_clr = 1'b1;
        issue(POP, 32'h0, 32'h0, 32'h0);
        err_clr = 1'b0;
        chk("lit_set_wins", unf, 1);

        // fill the stack to the limit, then overflow
        do_reset();
        for (int i = 0; i < 64; i++) issue(PUSH, 32'h0, 32'(i), 32'h0);
        idle(2);
        chk("lit_fill_sp", sp, 32'd768);
        chk("lit_fill_writes", log_q.size(), 64);
        if (log_q.size() == 64) chk("lit_fill_last_addr", log_q[63].addr, 32'd768);
        log_q.delete();
        issue(PUSH, 32'h0, 32'h55, 32'h0);
        chk("lit_ovf_flags", {ovf, op_err}, 2'b11);
        chk("lit_ovf_sp", sp, 32'd768);
        idle(2);
        chk("lit_ovf_no_write", log_q.size(), 0);
        issue(CALL, 32'h0, 32'h0, 32'h9);
        chk("lit_call_ovf_sp", sp, 32'd768);
        issue(POP, 32'h0, 32'h0, 32'h0);
        chk("lit_pop_after_full_sp", sp, 32'd772);

        // address checks and plain loads/stores
        do_reset();
        issue(LW, 32'h102, 32'h0, 32'h0);
        chk("lit_misalign_err", {addr_err, op_err}, 2'b11);
        issue(LW, 32'd1024, 32'h0, 32'h0);
        chk("lit_above_top_err", op_err, 1);
        issue(LW, 32'd1020, 32'h0, 32'h0);
        chk("lit_top_ok", op_err, 0);
        issue(SW, 32'h100, 32'd5, 32'h0);
        issue(6'h3F, 32'h0, 32'h0, 32'h0);
        chk("lit_other_op", {out_valid, op_err}, 2'b10);
        idle(2);
        chk("lit_addr_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("lit_lw_top", {log_q[0].wr, log_q[0].addr}, {1'b0, 32'd1020});
            chk("lit_sw", {log_q[1].wr, log_q[1].addr, log_q[1].data}, {1'b1, 32'h100, 32'd5});
        end
        chk("lit_other_sp", sp, 32'd1024);

        // back-to-back PUSH, PUSH, POP
        do_reset();
        issue(PUSH, 32'h0, 32'hA, 32'h0);
        issue(PUSH, 32'h0, 32'hB, 32'h0);
        issue(POP, 32'h0, 32'h0, 32'h0);
        idle(2);
        chk("lit_b2b_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("lit_b2b_addrs", {log_q[0].addr, log_q[1].addr, log_q[2].addr},
                {32'd1020, 32'd1016, 32'd1016});
            chk("lit_b2b_kinds", {log_q[0].wr, log_q[1].wr, log_q[2].wr}, 3'b110);
            chk("lit_b2b_consec", {log_q[1].cyc - log_q[0].cyc, log_q[2].cyc - log_q[1].cyc},
                {32'd1, 32'd1});
        end
        chk("lit_b2b_sp", sp, 32'd1020);

        // reset during a stall discards the held op
        log_q.delete();
        out_ready = 1'b0;
        issue(SW, 32'h10, 32'd7, 32'h0);
        idle(1);
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        chk("lit_rst_stall_ready", in_ready, 1);
        idle(3);
        chk("lit_rst_stall_no_strobe", log_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be: SP_INIT, default 1024, is the empty-stack pointer value; STACK_LIMIT, default 768, is the lowest legal stack word address; MEM_TOP, default 1020, is the highest legal word address.
REQ-002 Port `clk`, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port `rst_n`, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-004 Port `in_valid`, input, 1 bit, SHALL mean an execute-stage operation is presented.
REQ-005 Port `in_ready`, output, 1 bit, SHALL mean this block accepts the presented operation this cycle.
REQ-006 Port `opcode`, input, 6 bits, SHALL carry the operation: LW=000101, SW=000111, PUSH=001111, POP=010000, CALL=001101, RET=001110.
REQ-007 Port `alu_result`, input, 32 bits, SHALL be the LW/SW effective byte address.
REQ-008 Port `rd_data`, input, 32 bits, SHALL be the SW/PUSH store data.
REQ-009 Port `pc`, input, 32 bits, SHALL be the PC of the operation.
REQ-010 Port `out_ready`, input, 1 bit, SHALL mean the data memory/writeback side accepts the output this cycle.
REQ-011 Port `out_valid`, output, 1 bit, SHALL mean the registered output holds an operation.
REQ-012 Ports `mem_read` and `mem_write`, outputs, 1 bit each, SHALL be the data-memory read and write strobes.
REQ-013 Ports `mem_addr` and `mem_wdata`, outputs, 32 bits each, SHALL be the word byte address and the write data to the data memory.
REQ-014 Port `sp`, output, 32 bits, SHALL be the current stack pointer.
REQ-015 Port `is_ret`, output, 1 bit, SHALL flag a registered RET, so that read data is the return PC.
REQ-016 Port `op_err`, output, 1 bit, SHALL flag a registered operation whose memory access was suppressed.
REQ-017 Ports `ovf`, `unf` and `addr_err`, outputs, 1 bit each, SHALL be the sticky stack-overflow, stack-underflow and bad-address flags.
REQ-018 Port `err_clr`, input, 1 bit, SHALL be a synchronous clear of all sticky flags.

Function
REQ-019 `in_ready` SHALL equal `!out_valid || out_ready`; an operation is accepted when `in_valid && in_ready`.
REQ-020 On accept, the block SHALL register `mem_addr`, `mem_wdata`, the operation type and the error state, and SHALL set `out_valid` the next cycle, giving 1-cycle latency.
REQ-021 If `out_valid && out_ready` with no new accept, `out_valid` SHALL clear next cycle.
REQ-022 If transfer and accept occur in the same cycle, the new operation SHALL load back-to-back with no bubble.
REQ-023 `mem_read`/`mem_write` SHALL be asserted only while `out_valid && out_ready` and the registered operation is a non-errored read/write, so that exactly one strobe cycle occurs per operation regardless of stall length.
REQ-024 LW SHALL register: addr=`alu_result`; read.
REQ-025 SW SHALL register: addr=`alu_result`; wdata=`rd_data`; write.
REQ-026 PUSH SHALL register: addr=`sp`-4; wdata=`rd_data`; write; `sp`<=`sp`-4 on accept.
REQ-027 CALL SHALL register: addr=`sp`-4; wdata=`pc`+1 (mod 2^32); write; `sp`<=`sp`-4 on accept.
REQ-028 POP SHALL register: addr=`sp`; read; `sp`<=`sp`+4 on accept.
REQ-029 RET SHALL register the same as POP and additionally set `is_ret`=1.
REQ-030 Any other opcode SHALL pass through with `out_valid` asserted and no strobes, `op_err`=0 and `sp` unchanged.
REQ-031 PUSH/CALL with `sp`-4 < STACK_LIMIT SHALL suppress the write, leave `sp` unchanged, set `op_err`, and set `ovf` sticky.
REQ-032 POP/RET with `sp` >= SP_INIT SHALL suppress the read, leave `sp` unchanged, set `op_err`, and set `unf` sticky.
REQ-033 LW/SW with `alu_result[1:0]`!=0 or `alu_result`>MEM_TOP SHALL suppress the access, set `op_err`, and set `addr_err` sticky.
REQ-034 `sp` SHALL change only on accept, never during a stall.
REQ-035 When `err_clr` coincides with a new error, the flag SHALL be set, with set winning over clear.
REQ-036 `sp` arithmetic SHALL be 32-bit unsigned, with comparisons unsigned.

Reset
REQ-037 While `rst_n`=0, the block SHALL hold: `out_valid`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `is_ret`=0, `op_err`=0, `ovf`=0, `unf`=0, `addr_err`=0, `sp`=SP_INIT.
REQ-038 Reset asserted mid-stall SHALL discard the held operation with no strobe issued; `in_ready`=1 once reset is released.

Verification
REQ-039 After reset, CALL with `pc`=0x40 SHALL give one `mem_write` at addr 1020 with wdata 0x41 and `sp`=1020; a following RET SHALL give `mem_read` at 1020, `is_ret`=1 and `sp`=1024.
REQ-040 PUSH 0xDEADBEEF with `out_ready`=0 for 3 cycles SHALL hold `in_ready`=0, keep `sp`=1020 and issue exactly one write strobe when `out_ready` rises.
REQ-041 POP immediately after reset SHALL give `op_err`=1, `unf`=1, no strobe and `sp`=1024; then `err_clr` SHALL clear `unf`.
REQ-042 64 PUSHes SHALL reach `sp`=768; the 65th PUSH SHALL give `ovf`=1, no write and `sp`=768.
REQ-043 LW at 0x102 SHALL give `addr_err`=1 and no read; SW at 0x100 with `rd_data`=5 SHALL write 5 at addr 0x100.
REQ-044 Back-to-back PUSH, PUSH, POP with `out_ready`=1 SHALL yield three consecutive strobe cycles at addrs 1020, 1016, 1016 and final `sp`=1020.
